fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//   Instruction-fetch stage plus IF/ID pipeline register for the 5-stage MIPS core.
//   Holds the PC and drives the instruction-memory address (combinational-read IMEM).
//   Accepts branch/jump redirects from decode and stall/flush from the hazard unit.
//   Registers {instruction, PC+4, valid} for the decode stage.
// PARAMETERS
//   RESET_PC   32'h0000_0000  PC value loaded on reset; bits [1:0] must be 0
//   NOP_INSTR  32'h0000_0000  word injected into InstructionD on reset/flush (sll $0,$0,0)
// PORTS
//   Clk           in   1   core clock; all state updates on rising edge
//   Reset         in   1   synchronous, active-high reset
//   StallF        in   1   hold PC (no PC update this cycle)
//   StallD        in   1   hold IF/ID register contents
//   FlushD        in   1   load NOP bubble into IF/ID
//   PCSrcD        in   1   redirect request from decode (taken branch / jump)
//   PCTargetD     in   32  redirect target; bits [1:0] ignored
//   InstrDataF    in   32  IMEM read data for address InstrAddrF (same cycle)
//   InstrAddrF    out  32  IMEM address = current PC (combinational from PC reg)
//   PCPlus4F      out  32  PC + 4 (combinational)
//   InstructionD  out  32  registered instruction for decode
//   PCPlus4D      out  32  registered PC+4 for decode
//   ValidD        out  1   1 = InstructionD is a real fetched instruction, 0 = bubble
//   BubbleCount   out  16  saturating count of bubbles inserted by FlushD
// BEHAVIOUR
//   Reset (sync, highest priority): PC<=RESET_PC, InstructionD<=NOP_INSTR,
//     PCPlus4D<=0, ValidD<=0, BubbleCount<=0. Reset mid-stall/flush overrides all.
//   PC update priority, per edge: Reset > StallF (hold) > PCSrcD (PC<={PCTargetD[31:2],2'b00})
//     > sequential (PC<=PC+4). Decode must hold PCSrcD until StallF drops; redirect is
//     not latched internally while stalled.
//   PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000. PC[1:0] always 0.
//   IF/ID update priority, per edge: Reset > FlushD > StallD > load.
//     FlushD: InstructionD<=NOP_INSTR, PCPlus4D<=0, ValidD<=0 (flush wins over StallD).
//     StallD: all three hold. Load: InstructionD<=InstrDataF, PCPlus4D<=PCPlus4F, ValidD<=1.
//   Latency: instruction at PC appears on InstructionD one edge after PC is presented.
//   Redirect: PCSrcD high in cycle N -> InstrAddrF=target in cycle N+1; the wrong-path
//     word fetched in cycle N is removed only if hazard unit asserts FlushD in cycle N.
//   StallF=1 with StallD=0 is legal: IF/ID reloads the same PC's instruction each cycle.
//   BubbleCount increments by 1 on each edge where FlushD=1 and Reset=0;
//     saturates at 16'hFFFF (no wrap).
//   No combinational path from any input to InstructionD/PCPlus4D/ValidD/BubbleCount;
//     InstrAddrF/PCPlus4F depend only on the PC register.
// TESTING
//   Reset 2 cycles then release, IMEM = word(addr) -> cycle1 InstrAddrF=0, ValidD=0;
//     then InstructionD=word(0),PCPlus4D=4,ValidD=1; next word(4),PCPlus4D=8.
//   StallF=StallD=1 for 3 cycles at PC=0x10 -> InstrAddrF stays 0x10, IF/ID frozen;
//     release -> fetch resumes 0x14 next edge with no skipped/duplicated ValidD words.
//   PCSrcD=1, PCTargetD=0x0000_0103, FlushD=1 same cycle -> next InstrAddrF=0x100,
//     InstructionD=NOP_INSTR, ValidD=0, BubbleCount+1; following edge InstructionD=word(0x100).
//   FlushD=1 and StallD=1 together -> bubble loaded (ValidD=0), PC still advances if StallF=0.
//   PC=0xFFFF_FFFC, no stall -> next InstrAddrF=0x0000_0000, PCPlus4D=0x0000_0000.
//   Hold FlushD=1 for 65540 cycles -> BubbleCount=16'hFFFF, stays; Reset -> 0 on next edge.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: PC register with redirect/stall plus IF/ID pipeline register and flush bubble counter
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcD,
  input  logic [31:0] PCTargetD,
  input  logic [31:0] InstrDataF,
  output logic [31:0] InstrAddrF,
  output logic [31:0] PCPlus4F,
  output logic [31:0] InstructionD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic [15:0] BubbleCount
);
  logic [31:0] pc_q, pc_d, instr_q, instr_d, pcp4_q, pcp4_d;
  logic        valid_q, valid_d;
  logic [15:0] bubble_q, bubble_d;
  assign InstrAddrF   = pc_q;
  assign PCPlus4F     = pc_q + 32'd4;
  assign InstructionD = instr_q;
  assign PCPlus4D     = pcp4_q;
  assign ValidD       = valid_q;
  assign BubbleCount  = bubble_q;
  // next PC, IF/ID contents and bubble count; flush beats stall on IF/ID
  always_comb begin
    pc_d     = StallF ? pc_q : PCSrcD ? {PCTargetD[31:2], 2'b00} : PCPlus4F;
    instr_d  = FlushD ? NOP_INSTR : StallD ? instr_q : InstrDataF;
    pcp4_d   = FlushD ? 32'd0 : StallD ? pcp4_q : PCPlus4F;
    valid_d  = FlushD ? 1'b0 : StallD ? valid_q : 1'b1;
    bubble_d = (FlushD && bubble_q != 16'hFFFF) ? bubble_q + 16'd1 : bubble_q;
  end
  // state registers with synchronous reset overriding everything
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc_q     <= {RESET_PC[31:2], 2'b00};
      instr_q  <= NOP_INSTR;
      pcp4_q   <= 32'd0;
      valid_q  <= 1'b0;
      bubble_q <= 16'd0;
    end else begin
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pcp4_q   <= pcp4_d;
      valid_q  <= valid_d;
      bubble_q <= bubble_d;
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scoreboard bench for fetch_stage
module tb_fetch_stage;
  logic        Clk = 0, Reset, StallF, StallD, FlushD, PCSrcD;
  logic [31:0] PCTargetD, InstrDataF, InstrAddrF, PCPlus4F, InstructionD, PCPlus4D;
  logic        ValidD;
  logic [15:0] BubbleCount;
  typedef struct {logic [31:0] instr; logic [31:0] p4; logic valid; logic [15:0] bub;} exp_t;
  exp_t        sb[$];
  int          tests = 0, fails = 0;
  logic [31:0] m_pc, m_instr, m_p4;
  logic        m_valid;
  logic [15:0] m_bub;
  localparam logic [31:0] NOP = 32'h0000_0000;

  fetch_stage dut (.Clk(Clk), .Reset(Reset), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .PCSrcD(PCSrcD), .PCTargetD(PCTargetD), .InstrDataF(InstrDataF), .InstrAddrF(InstrAddrF),
    .PCPlus4F(PCPlus4F), .InstructionD(InstructionD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
    .BubbleCount(BubbleCount));

  always #5 Clk = ~Clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hC0DE_5A5A;
  endfunction

  assign InstrDataF = word(InstrAddrF);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input logic r, sf, sd, fl, ps, input logic [31:0] tg);
    exp_t e;
    Reset = r; StallF = sf; StallD = sd; FlushD = fl; PCSrcD = ps; PCTargetD = tg;
    #1;
    chk("InstrAddrF", InstrAddrF, m_pc);
    chk("PCPlus4F", PCPlus4F, m_pc + 32'd4);
    if (r || fl) begin
      m_instr = NOP; m_p4 = 0; m_valid = 0;
    end else if (!sd) begin
      m_instr = word(m_pc); m_p4 = m_pc + 32'd4; m_valid = 1;
    end
    m_bub = r ? 16'd0 : (fl && m_bub != 16'hFFFF) ? m_bub + 16'd1 : m_bub;
    m_pc = r ? 32'd0 : sf ? m_pc : ps ? {tg[31:2], 2'b00} : m_pc + 32'd4;
    e.instr = m_instr; e.p4 = m_p4; e.valid = m_valid; e.bub = m_bub;
    sb.push_back(e);
    @(posedge Clk);
    #1;
    e = sb.pop_front();
    chk("InstructionD", InstructionD, e.instr);
    chk("PCPlus4D", PCPlus4D, e.p4);
    chk("ValidD", {31'd0, ValidD}, {31'd0, e.valid});
    chk("BubbleCount", {16'd0, BubbleCount}, {16'd0, e.bub});
    @(negedge Clk);
  endtask

  initial begin
    Reset = 1; StallF = 0; StallD = 0; FlushD = 0; PCSrcD = 0; PCTargetD = 0;
    @(posedge Clk);
    @(negedge Clk);
    m_pc = 0; m_instr = NOP; m_p4 = 0; m_valid = 0; m_bub = 0;
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 2; i++) step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 32'h0000_0103);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 1, 32'hFFFF_FFFC);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) step(0, 1, 0, 0, 0, 0);
    step(1, 1, 1, 1, 1, 32'h0000_0200);
    step(0, 0, 0, 0, 0, 0);
    Reset = 0; StallF = 1; StallD = 0; FlushD = 1; PCSrcD = 0;
    repeat (65540) @(posedge Clk);
    @(negedge Clk);
    m_bub = 16'hFFFF; m_instr = NOP; m_p4 = 0; m_valid = 0;
    step(0, 1, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
